// File: rtl/peridot_servo_pkg.sv
// Shared constants, state encoding and width-to-step conversion for the
// PERIDOT servo generator/capture pair.
package peridot_servo_pkg;

   localparam int UNITFREQ     = 128000;
   localparam int STEPCOUNTNUM = 2560;

   localparam logic [8:0]  MINWIDTHSTEP    = 9'd64;
   localparam logic [8:0]  CAP_GLITCHSTEP  = 9'd32;
   localparam logic [8:0]  CAP_MAXSTEP     = 9'd400;
   localparam logic [12:0] CAP_TIMEOUTSTEP = 13'd7680;

   localparam int AVS_ADDR_W = 5;
   localparam int AVS_DATA_W = 32;
   localparam int CAP_STAT_W = 10;

   typedef enum logic [1:0] {
      ST_ARM,
      ST_IDLE,
      ST_HIGH,
      ST_OVER
   } cap_state_e;

   // Step code the generator consumes: 0 = 0.5 ms, 255 = 2.49 ms.
   function automatic logic [7:0] width_to_step(input logic [8:0] width);
      logic [8:0] d;
      if (width <= MINWIDTHSTEP) return 8'd0;
      d = width - MINWIDTHSTEP;
      return (d > 9'd255) ? 8'hFF : d[7:0];
   endfunction

endpackage

// File: rtl/peridot_servo_capture_if.sv
// Avalon-MM slave bus for the servo capture block.
interface peridot_servo_capture_if;
   import peridot_servo_pkg::*;

   logic [AVS_ADDR_W-1:0] avs_address;
   logic                  avs_read;
   logic [AVS_DATA_W-1:0] avs_readdata;
   logic                  avs_write;
   logic [AVS_DATA_W-1:0] avs_writedata;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );

endinterface

// File: rtl/peridot_servo_capch.sv
// One capture channel: input synchronizer, pulse FSM, width/timeout counters
// and the value/valid/new status it reports.
module peridot_servo_capch
   import peridot_servo_pkg::*;
(
   input  logic                  csi_clk,
   input  logic                  rsi_reset_n,
   input  logic                  cap_in,
   input  logic                  tick,
   input  logic                  enable,
   input  logic                  rdclr,
   output logic [CAP_STAT_W-1:0] status
);

   logic [1:0]  sync;
   logic        prev;
   cap_state_e  state;
   logic [8:0]  wcnt;
   logic [12:0] tcnt;
   logic [7:0]  value;
   logic        valid;
   logic        newf;
   logic        rise, fall, accept;

   assign rise   = sync[1] & ~prev;
   assign fall   = ~sync[1] & prev;
   assign accept = enable && (state == ST_HIGH) && fall &&
                   (wcnt >= CAP_GLITCHSTEP) && (wcnt <= CAP_MAXSTEP);
   assign status = {newf, valid, value};

   always_ff @(posedge csi_clk) begin
      if (!rsi_reset_n) begin
         sync  <= '0;
         prev  <= 1'b0;
         state <= ST_ARM;
         wcnt  <= '0;
         tcnt  <= '0;
         value <= '0;
         valid <= 1'b0;
         newf  <= 1'b0;
      end else begin
         sync <= {sync[0], cap_in};
         prev <= sync[1];

         // A fresh capture wins over a clear-on-read in the same cycle.
         if (accept)     newf <= 1'b1;
         else if (rdclr) newf <= 1'b0;

         if (!enable) begin
            state <= ST_ARM;
            wcnt  <= '0;
            tcnt  <= '0;
            valid <= 1'b0;
         end else begin
            if (tick && tcnt != '1) tcnt <= tcnt + 13'd1;
            if (tick && tcnt == CAP_TIMEOUTSTEP - 13'd1) valid <= 1'b0;

            case (state)
               ST_ARM:  if (!sync[1]) state <= ST_IDLE;
               ST_IDLE: if (rise) begin
                  wcnt  <= '0;
                  state <= ST_HIGH;
               end
               ST_HIGH: begin
                  if (tick && wcnt != '1) wcnt <= wcnt + 9'd1;
                  if (wcnt > CAP_MAXSTEP) state <= ST_OVER;
                  else if (fall)          state <= ST_IDLE;
               end
               ST_OVER: if (!sync[1]) state <= ST_IDLE;
               default: state <= ST_ARM;
            endcase

            if (accept) begin
               value <= width_to_step(wcnt);
               valid <= 1'b1;
               tcnt  <= '0;
            end
         end
      end
   end

endmodule

// File: rtl/peridot_servo_capture.sv
// Multi-channel RC servo pulse capture with an Avalon-MM register window;
// widths are reported in the same step code the servo generator consumes.
module peridot_servo_capture
   import peridot_servo_pkg::*;
#(
   parameter int CAP_CHANNEL = 8,
   parameter int CLOCKFREQ   = 25000000
) (
   input  logic                   csi_clk,
   input  logic                   rsi_reset_n,
   peridot_servo_capture_if.slave avs,
   input  logic [CAP_CHANNEL-1:0] cap_in
);

   localparam logic [11:0] CLOCKDIV = 12'(CLOCKFREQ / UNITFREQ - 1);

   logic [11:0]                            divider;
   logic                                   tick;
   logic                                   cap_ena;
   logic [CAP_CHANNEL-1:0][CAP_STAT_W-1:0] status;
   logic [CAP_CHANNEL-1:0]                 valid_vec;
   logic [CAP_CHANNEL-1:0]                 rd_hit;
   logic [CAP_CHANNEL-1:0]                 rdclr;
   logic [CAP_STAT_W-1:0]                  ch_rd;
   logic                                   unused_wdata;

   assign tick         = (divider == 12'd0);
   assign unused_wdata = ^avs.avs_writedata[AVS_DATA_W-1:1];

   always_ff @(posedge csi_clk) begin
      if (!rsi_reset_n) begin
         divider <= '0;
         cap_ena <= 1'b0;
      end else begin
         divider <= tick ? CLOCKDIV : divider - 12'd1;
         if (avs.avs_write && avs.avs_address == AVS_ADDR_W'(0))
            cap_ena <= avs.avs_writedata[0];
      end
   end

   for (genvar i = 0; i < CAP_CHANNEL; i++) begin : g_ch
      assign rd_hit[i]    = (avs.avs_address == AVS_ADDR_W'(i + 2));
      assign rdclr[i]     = avs.avs_read & rd_hit[i];
      assign valid_vec[i] = status[i][8];

      peridot_servo_capch u_ch (
         .csi_clk     (csi_clk),
         .rsi_reset_n (rsi_reset_n),
         .cap_in      (cap_in[i]),
         .tick        (tick),
         .enable      (cap_ena),
         .rdclr       (rdclr[i]),
         .status      (status[i])
      );
   end

   always_comb begin
      ch_rd = '0;
      for (int i = 0; i < CAP_CHANNEL; i++)
         if (rd_hit[i]) ch_rd = status[i];
   end

   // Sampled every clock, so a read sees the status from before this edge.
   always_ff @(posedge csi_clk) begin
      if (!rsi_reset_n)
         avs.avs_readdata <= '0;
      else if (avs.avs_address == AVS_ADDR_W'(0))
         avs.avs_readdata <= AVS_DATA_W'(cap_ena);
      else if (avs.avs_address == AVS_ADDR_W'(1))
         avs.avs_readdata <= AVS_DATA_W'(valid_vec);
      else
         avs.avs_readdata <= AVS_DATA_W'(ch_rd);
   end

endmodule

// File: tb/tb_peridot_servo_capture.sv
// Scoreboard bench for peridot_servo_capture: pulses in real time against a
// per-channel model of value range, new flag and valid lifetime.
module tb_peridot_servo_capture;

   localparam int NCH  = 8;
   localparam int CLKF = 384000;
   localparam int P    = CLKF / 128000;   // clocks per step

   typedef struct {
      string       tag;
      logic [31:0] exp;
      logic [31:0] mask;
      bit          rng;
      int          lo;
      int          hi;
   } sb_t;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [NCH-1:0] cap   = '0;

   peridot_servo_capture_if bus();

   peridot_servo_capture #(.CAP_CHANNEL(NCH), .CLOCKFREQ(CLKF)) dut (
      .csi_clk     (clk),
      .rsi_reset_n (rst_n),
      .avs         (bus),
      .cap_in      (cap)
   );

   always #5 clk = ~clk;

   int  cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model
   bit  m_ena;
   int  mlo[NCH], mhi[NCH], acc_cyc[NCH];
   bit  mnew[NCH], macc[NCH];

   sb_t sbq[$];
   sb_t cur;
   int  ntests = 0, nfail = 0;
   bit  fin = 1'b0;
   logic rd_vld = 1'b0;
   bit  ok;

   function automatic int clamp8(input int v);
      return (v < 0) ? 0 : ((v > 255) ? 255 : v);
   endfunction

   // 0 = invalid, 1 = valid, 2 = too close to the 60 ms boundary to call
   function automatic int vstate(input int ch);
      int el;
      if (!macc[ch]) return 0;
      el = (cyc - acc_cyc[ch]) / P;
      if (el < 7678) return 1;
      if (el > 7682) return 0;
      return 2;
   endfunction

   task automatic model_reset();
      m_ena = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         mlo[i] = 0; mhi[i] = 0; mnew[i] = 1'b0; macc[i] = 1'b0; acc_cyc[i] = 0;
      end
   endtask

   task automatic model_fall(input int ch, input int steps);
      if (!m_ena || steps < 32 || steps > 400) return;
      mlo[ch]     = clamp8(steps - 1 - 64);
      mhi[ch]     = clamp8(steps + 1 - 64);
      mnew[ch]    = 1'b1;
      macc[ch]    = 1'b1;
      acc_cyc[ch] = cyc + 3;
   endtask

   // Called at a negedge: records the expectation, then strobes the read.
   task automatic issue_rd(input int addr, input string tag);
      sb_t e;
      int  vs;
      int  ch;
      e.tag = tag; e.exp = '0; e.mask = '1; e.rng = 1'b0; e.lo = 0; e.hi = 0;
      ch = addr - 2;
      if (addr == 0) begin
         e.exp[0] = m_ena;
      end else if (addr == 1) begin
         for (int i = 0; i < NCH; i++) begin
            vs = vstate(i);
            if (vs == 2) e.mask[i] = 1'b0;
            else         e.exp[i]  = (vs == 1);
         end
      end else if (ch < NCH) begin
         vs = vstate(ch);
         e.exp[9] = mnew[ch];
         if (vs == 2) e.mask[8] = 1'b0;
         else         e.exp[8]  = (vs == 1);
         e.mask[7:0] = '0;
         e.rng = 1'b1; e.lo = mlo[ch]; e.hi = mhi[ch];
         mnew[ch] = 1'b0;
      end
      sbq.push_back(e);
      bus.avs_address = 5'(addr);
      bus.avs_read    = 1'b1;
      @(negedge clk);
      bus.avs_read    = 1'b0;
   endtask

   task automatic rd(input int addr, input string tag);
      @(negedge clk);
      issue_rd(addr, tag);
   endtask

   task automatic wr(input int addr, input logic [31:0] d);
      @(negedge clk);
      bus.avs_address   = 5'(addr);
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      @(negedge clk);
      bus.avs_write     = 1'b0;
      if (addr == 0) begin
         if (m_ena && !d[0])
            for (int i = 0; i < NCH; i++) macc[i] = 1'b0;
         m_ena = d[0];
      end
   endtask

   task automatic pulse(input int ch, input int steps);
      @(negedge clk);
      cap[ch] = 1'b1;
      repeat (steps * P) @(negedge clk);
      cap[ch] = 1'b0;
      model_fall(ch, steps);
      repeat (6) @(negedge clk);
   endtask

   // Monitor: one response per read, the cycle after the strobe.
   always @(posedge clk) rd_vld <= bus.avs_read;

   always @(negedge clk) begin
      if (rd_vld) begin
         ntests++;
         if (sbq.size() == 0) begin
            nfail++;
            $display("FAIL sb_underflow: got %h, want no response", bus.avs_readdata);
         end else begin
            cur = sbq.pop_front();
            ok  = (((bus.avs_readdata ^ cur.exp) & cur.mask) == 32'd0);
            if (cur.rng && (int'(bus.avs_readdata[7:0]) < cur.lo ||
                            int'(bus.avs_readdata[7:0]) > cur.hi)) ok = 1'b0;
            if (!ok) begin
               nfail++;
               $display("FAIL %s: got %h, want %h (mask %h, value %0d..%0d)",
                        cur.tag, bus.avs_readdata, cur.exp, cur.mask, cur.lo, cur.hi);
            end
         end
      end
      if (fin && !rd_vld) begin
         ntests++;
         if (sbq.size() != 0) begin
            nfail++;
            $display("FAIL sb_drain: got %0d pending, want 0", sbq.size());
         end
         $display("[TB] %0d tests run, %0d failed", ntests, nfail);
         $finish;
      end
   end

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: got no finish, want finish within 90000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.avs_address   = '0;
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = '0;
      model_reset();
      repeat (4) @(negedge clk);
      rst_n = 1'b1;

      rd(0, "rst_ena"); rd(1, "rst_valid"); rd(2, "rst_ch0"); rd(31, "unimpl");
      wr(0, 32'd1);
      rd(0, "ena_on");
      repeat (10) @(negedge clk);

      pulse(0, 192); rd(2, "p1500"); rd(2, "p1500_newclr"); rd(1, "valid_ch0");
      pulse(0, 38);  rd(2, "p300_clamp");
      pulse(0, 25);  rd(2, "p200_glitch");
      pulse(0, 319); rd(2, "p2490_max");
      pulse(0, 512); rd(2, "over_hold");
      pulse(0, 128); rd(2, "p1000_after_over");

      for (int k = 0; k < 14; k++) begin
         int ch, st, kind;
         ch   = $urandom_range(NCH - 1, 0);
         kind = $urandom_range(3, 0);
         st   = (kind == 0) ? $urandom_range(25, 3) : $urandom_range(390, 40);
         repeat ($urandom_range(20, 2)) @(negedge clk);
         pulse(ch, st);
         rd(2 + ch, "rand_ch");
         if (kind == 1) rd(1, "rand_valid");
         if (kind == 2) rd($urandom_range(31, 2 + NCH), "rand_unimpl");
      end

      // 60 ms without a pulse drops valid
      pulse(0, 150); rd(2, "to_accept");
      while (cyc - acc_cyc[0] < 7670 * P) @(negedge clk);
      rd(2, "to_before");
      while (cyc - acc_cyc[0] < 7690 * P) @(negedge clk);
      rd(2, "to_after"); rd(1, "to_valid_vec");

      // enabling mid-pulse must not report the partial pulse
      wr(0, 32'd0); rd(0, "ena_off"); rd(1, "off_valid");
      @(negedge clk); cap[1] = 1'b1;
      repeat (20) @(negedge clk);
      wr(0, 32'd1);
      repeat (200 * P) @(negedge clk);
      cap[1] = 1'b0;
      repeat (6) @(negedge clk);
      rd(3, "partial_ignored");
      pulse(1, 100); rd(3, "after_partial");

      // read strobe lands on the accept edge
      rd(2, "pre_coinc");
      @(negedge clk); cap[0] = 1'b1;
      repeat (100 * P) @(negedge clk);
      cap[0] = 1'b0;
      @(negedge clk); @(negedge clk);
      issue_rd(2, "coinc_old");
      model_fall(0, 100);
      repeat (4) @(negedge clk);
      rd(2, "coinc_new");

      // one-clock reset in the middle of a pulse
      @(negedge clk); cap[0] = 1'b1;
      repeat (50 * P) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      repeat (50 * P) @(negedge clk);
      cap[0] = 1'b0;
      repeat (6) @(negedge clk);
      rd(0, "rst_mid_ena"); rd(2, "rst_mid_ch0"); rd(1, "rst_mid_valid");
      pulse(0, 60); rd(2, "dis_no_cap");
      wr(0, 32'd1);
      repeat (10) @(negedge clk);
      pulse(0, 160); rd(2, "reenable_cap");

      repeat (4) @(negedge clk);
      fin = 1'b1;
   end

endmodule

// File: doc/peridot_servo_capture.md
Name: peridot_servo_capture

Overview:
- Multi-channel RC servo pulse capture: measures the high width of standard servo pulses (0.5–2.5 ms, 20 ms frame) on input pins.
- Converts each width to the same 8-bit step code our servo PWM generator consumes, so a captured value written back to the generator reproduces the pulse.
- Avalon-MM slave on the peripheral clock; sits beside the servo generator in the PERIDOT peripheral set.

Parameters:
- CAP_CHANNEL, 8, number of input channels, 1–30
- CLOCKFREQ, 25000000, peripheral clock frequency in Hz

Ports:
- csi_clk  in  1  peripheral clock; all logic on rising edge
- rsi_reset_n  in  1  synchronous, active-low reset
- avs_address  in  5  register word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  registered read data
- avs_write  in  1  write strobe, single cycle
- avs_writedata  in  32  write data
- cap_in  in  CAP_CHANNEL  asynchronous servo pulse inputs

Behaviour:
- Reset (rsi_reset_n=0 at a clock edge): avs_readdata=0, cap_ena=0, divider=0, and every channel has state=ARM, value=0, valid=0, new=0, counters=0.
- Tick: local 12-bit divider loads CLOCKDIV=(CLOCKFREQ/128000)-1 and runs freely. tick=1 for one clock when divider==0, giving 7.8125 us per step; 128 steps=1 ms.
- Register map:
  - addr 0: bit0 cap_ena, R/W.
  - addr 1: valid[CAP_CHANNEL-1:0], read-only.
  - addr 2+i: bits[7:0] value, bit8 valid, bit9 new; writes ignored.
  - Unimplemented addresses read 0.
- Read timing: avs_readdata is registered every clock from avs_address, so data is ready the clock after the address is presented.
- Clear-on-read: a read of addr 2+i with avs_read=1 clears new[i] at that edge.
- Input conditioning: each cap_in bit passes through a 2-FF synchronizer plus a previous-level register for edge detection.
- Per-channel FSM (advances only while cap_ena=1; width counter is 9-bit, saturating, incremented on tick):
  - ARM: wait for synchronized input = 0, then go to IDLE. This prevents capturing a partial pulse.
  - IDLE: on a rising edge, clear the width counter and go to HIGH.
  - HIGH: count ticks while high.
    - Counter exceeds 400 → OVER.
    - Falling edge with 32 ≤ width ≤ 400 → accept; go to IDLE.
    - Falling edge with width < 32 → reject as a glitch; go to IDLE with no register change.
  - OVER: wait for input = 0, then go to IDLE; the pulse is discarded.
- Accept action: value = clamp(width-64, 0, 255); valid=1; new=1; timeout counter cleared.
- Timeout: 13-bit counter per channel, incremented on tick, saturating.
  - Cleared on each accepted pulse.
  - Reaching 7680 (about 60 ms, 3 frames) clears valid. value and new are held.
- Simultaneous accept and clear-on-read in the same clock: new ends at 1, and the read returns the pre-update contents.
- cap_ena 1→0: all channels return to ARM at the next edge, valid is cleared, value and new are held, and timeout and width counters are cleared. Writing cap_ena=1 starts from ARM.
- Reset mid-pulse: the channel restarts in ARM, so the in-flight pulse is never reported.
- Quantization: measured width is accurate to ±1 step because the tick phase is unsynchronized to the input.

Decomposition:
- Shared package (peridot_servo_pkg):
  - UNITFREQ=128000
  - STEPCOUNTNUM=2560
  - MINWIDTHSTEP=64
  - CAP_GLITCHSTEP=32
  - CAP_MAXSTEP=400
  - CAP_TIMEOUTSTEP=7680
  - FSM state encoding ARM/IDLE/HIGH/OVER
- Sub-module peridot_servo_capch:
  - One instance per channel.
  - Contains the synchronizer, FSM, width counter, timeout counter, and value/valid/new registers.
  - Inputs: tick, enable, read-clear; outputs: 10-bit status.
  - Top level holds the divider, cap_ena, address decode and readdata mux.

Test Plan:
- cap_ena=1, ch0 low then 1.5 ms high (192 steps) → read addr 2 gives value 128±1, valid=1, new=1. A second read gives new=0; addr 1 bit0=1.
- Pulse 0.3 ms (≈38 steps) → value=0 (clamped), valid=1. Pulse 0.2 ms (≈25 steps) → no change; new stays 0.
- Pulse 2.49 ms (319 steps) → value=255. Input held high 4 ms → OVER; no update; the next 1.0 ms pulse gives value 64±1.
- Accept one pulse, then hold low 60 ms → valid drops to 0 after 7680 ticks ±1; value is unchanged; addr 1 bit clears.
- Enable while input is already high mid-pulse → first partial pulse ignored (ARM), the following full pulse is captured. A falling edge coinciding with a read of addr 2 → read returns old data and new=1 afterwards.
- Assert rsi_reset_n=0 for one clock during HIGH → all registers 0 and avs_readdata=0. cap_ena must be rewritten, and no capture occurs until a clean pulse after re-enable.
